// File: rtl/mux_scan_ctrl_pkg.sv
// mux_scan_ctrl shared definitions: state encoding, channel/select widths.
// Imported by the scan controller, its interface and the channel picker.
package mux_scan_ctrl_pkg;

    localparam int NCH         = 4;
    localparam int SEL_W       = 2;
    localparam int DWELL_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [NCH-1:0]   chmask_t;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Request/response bundle between a scan requester and mux_scan_ctrl.
// Optional MUX_SCAN_CONT_EN adds the cont (continuous rescan) request bit.
interface mux_scan_ctrl_if
    import mux_scan_ctrl_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DEF
);

    logic               start;
    chmask_t            ch_mask;
    logic [DWELL_W-1:0] dwell;
`ifdef MUX_SCAN_CONT_EN
    logic               cont;
`endif
    logic               busy;
    logic               done;
    chmask_t            snapshot;
    logic               snap_valid;

    modport master (
`ifdef MUX_SCAN_CONT_EN
        output cont,
`endif
        output start,
        output ch_mask,
        output dwell,
        input  busy,
        input  done,
        input  snapshot,
        input  snap_valid
    );

    modport slave (
`ifdef MUX_SCAN_CONT_EN
        input  cont,
`endif
        input  start,
        input  ch_mask,
        input  dwell,
        output busy,
        output done,
        output snapshot,
        output snap_valid
    );

endinterface

// File: rtl/mux_scan_ctrl_pick.sv
// Channel picker: lowest enabled channel (first=1) or the next enabled
// channel strictly above cur (first=0); found=0 when none qualifies.
module mux_scan_ctrl_pick
    import mux_scan_ctrl_pkg::*;
(
    input  chmask_t mask,
    input  sel_t    cur,
    input  logic    first,
    output sel_t    idx,
    output logic    found
);

    // Descending walk so the lowest qualifying channel is the last one kept.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i] && (first || (i > int'(cur)))) begin
                idx   = sel_t'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 4:1 mux select over enabled channels and snapshots
// the mux output. Optional MUX_SCAN_CONT_EN enables continuous rescanning.
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux_scan_ctrl_if.slave       ctl,
    input  logic                 mux_out,
    output sel_t                 sel
);

    state_t             state_q, state_d;
    sel_t               sel_q, sel_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    chmask_t            snap_q, snap_d;
    logic               snapv_q, snapv_d;
    chmask_t            work_q, work_d;
    chmask_t            mask_q, mask_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;

    chmask_t            pick_mask;
    sel_t               pick_cur;
    logic               pick_first;
    sel_t               pick_idx;
    logic               pick_found;

    // Picker sees the live mask in IDLE, the latched mask otherwise.
    always_comb begin
        pick_mask  = mask_q;
        pick_cur   = sel_q;
        pick_first = 1'b1;
        case (state_q)
            ST_IDLE:   pick_mask  = ctl.ch_mask;
            ST_SETTLE: pick_first = 1'b0;
            default:   pick_first = 1'b1;
        endcase
    end

    mux_scan_ctrl_pick u_pick (
        .mask  (pick_mask),
        .cur   (pick_cur),
        .first (pick_first),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Next-state and next-output computation for the scan sequencer.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        snap_d  = snap_q;
        snapv_d = snapv_q;
        work_d  = work_q;
        mask_d  = mask_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (ctl.start) begin
                    mask_d  = ctl.ch_mask;
                    dwell_d = ctl.dwell;
                    work_d  = '0;
                    if (pick_found) begin
                        snapv_d = 1'b0;
                        sel_d   = pick_idx;
                        cnt_d   = ctl.dwell;
                        busy_d  = 1'b1;
                        state_d = ST_SETTLE;
                    end else begin
                        snap_d  = '0;
                        snapv_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end

            ST_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    work_d[sel_q] = mux_out;
                    if (pick_found) begin
                        sel_d = pick_idx;
                        cnt_d = dwell_q;
                    end else begin
                        snap_d  = work_d;
                        snapv_d = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
`ifdef MUX_SCAN_CONT_EN
                if (ctl.cont) begin
                    work_d = '0;
                    if (pick_found) begin
                        sel_d   = pick_idx;
                        cnt_d   = dwell_q;
                        busy_d  = 1'b1;
                        state_d = ST_SETTLE;
                    end else begin
                        snap_d  = '0;
                        snapv_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
`endif
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            snap_q  <= '0;
            snapv_q <= 1'b0;
            work_q  <= '0;
            mask_q  <= '0;
            dwell_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            snap_q  <= snap_d;
            snapv_q <= snapv_d;
            work_q  <= work_d;
            mask_q  <= mask_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sel            = sel_q;
    assign ctl.busy       = busy_q;
    assign ctl.done       = done_q;
    assign ctl.snapshot   = snap_q;
    assign ctl.snap_valid = snapv_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: per-cycle trace model plus
// directed literal expectations (continuous mode under MUX_SCAN_CONT_EN).
module tb_mux_scan_ctrl;

    typedef struct packed {
        logic [1:0] sel;
        logic       busy;
        logic       done;
        logic [3:0] snap;
        logic       sv;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       mux_out;
    logic [1:0] sel;
    logic [3:0] in_pat;

    mux_scan_ctrl_if #(.DWELL_W(8)) bus ();

    mux_scan_ctrl #(.DWELL_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ctl     (bus),
        .mux_out (mux_out),
        .sel     (sel)
    );

    assign mux_out = in_pat[sel];

    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   t0       = 0;
    int   done_cnt = 0;
    int   done_at  = -1;
    int   busy_cnt = 0;
    bit   chk_on   = 0;
    exp_t q[$];
    exp_t tail_e;
    exp_t cur_e;
    exp_t cmp_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input exp_t e);
        q.push_back(e);
        tail_e = e;
    endtask

    // Expected per-cycle trace of one scan pass, from the scan rules:
    // each enabled channel holds sel for dwell+1 cycles, then one DONE cycle.
    task automatic expect_scan(input logic [3:0] mask, input int dw,
                               input logic [3:0] inp, input bit fresh);
        exp_t e;
        if (fresh) begin
            e      = tail_e;
            e.busy = 1'b0;
            e.done = 1'b0;
            push(e);
        end
        e      = tail_e;
        e.done = 1'b0;
        if (mask != 4'b0) begin
            if (fresh) e.sv = 1'b0;
            for (int ch = 0; ch < 4; ch++) begin
                if (mask[ch]) begin
                    for (int k = 0; k <= dw; k++) begin
                        e.sel  = 2'(ch);
                        e.busy = 1'b1;
                        push(e);
                    end
                end
            end
            e.busy = 1'b0;
            e.done = 1'b1;
            e.snap = inp & mask;
            e.sv   = 1'b1;
            push(e);
        end else begin
            e.busy = 1'b0;
            e.done = 1'b1;
            e.snap = 4'b0;
            e.sv   = 1'b1;
            push(e);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the trace model.
    always @(negedge clk) begin
        if (chk_on) begin
            if (q.size() > 0) begin
                cmp_e = q.pop_front();
                cur_e = cmp_e;
            end else begin
                cmp_e      = cur_e;
                cmp_e.busy = 1'b0;
                cmp_e.done = 1'b0;
            end
            chk("sel",        32'(sel),            32'(cmp_e.sel));
            chk("busy",       32'(bus.busy),       32'(cmp_e.busy));
            chk("done",       32'(bus.done),       32'(cmp_e.done));
            chk("snapshot",   32'(bus.snapshot),   32'(cmp_e.snap));
            chk("snap_valid", 32'(bus.snap_valid), 32'(cmp_e.sv));
        end
    end

    // Done/busy event monitor used by the literal expectations.
    always @(negedge clk) begin
        if (bus.done) begin
            done_cnt++;
            done_at = cyc - t0;
        end
        if (bus.busy) busy_cnt++;
    end

    task automatic run_scan(input logic [3:0] mask, input int dw,
                            input logic [3:0] inp);
        bus.ch_mask = mask;
        bus.dwell   = 8'(dw);
        in_pat      = inp;
        bus.start   = 1'b1;
        t0          = cyc;
        done_cnt    = 0;
        done_at     = -1;
        busy_cnt    = 0;
        expect_scan(mask, dw, inp, 1'b1);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d trace entries left, required 0",
                     q.size());
            q.delete();
        end
        tick();
        tick();
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.ch_mask = 4'b0;
        bus.dwell   = 8'd0;
`ifdef MUX_SCAN_CONT_EN
        bus.cont    = 1'b0;
`endif
        in_pat      = 4'b0;
        tick();
        tick();
        tick();
        chk("rst_sel",   32'(sel),            32'd0);
        chk("rst_busy",  32'(bus.busy),       32'd0);
        chk("rst_done",  32'(bus.done),       32'd0);
        chk("rst_snap",  32'(bus.snapshot),   32'd0);
        chk("rst_valid", 32'(bus.snap_valid), 32'd0);
        rst_n  = 1'b1;
        cur_e  = '0;
        tail_e = '0;
        chk_on = 1'b1;
        tick();

        // Basic scan with ignored starts and mid-scan input changes.
        run_scan(4'b1111, 0, 4'b1010);
        bus.start   = 1'b1;
        bus.ch_mask = 4'b0000;
        bus.dwell   = 8'd9;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        drain(20);
        chk("basic_done_cnt", 32'(done_cnt),         32'd1);
        chk("basic_done_at",  32'(done_at),          32'd5);
        chk("basic_busy_cyc", 32'(busy_cnt),         32'd4);
        chk("basic_snap",     32'(bus.snapshot),     32'b1010);
        chk("basic_valid",    32'(bus.snap_valid),   32'd1);

        // Sparse mask with dwell.
        run_scan(4'b0101, 2, 4'b1111);
        drain(20);
        chk("sparse_done_at", 32'(done_at),      32'd7);
        chk("sparse_snap",    32'(bus.snapshot), 32'b0101);

        // Empty mask.
        run_scan(4'b0000, 0, 4'b1111);
        drain(10);
        chk("empty_done_at", 32'(done_at),        32'd1);
        chk("empty_busy",    32'(busy_cnt),       32'd0);
        chk("empty_snap",    32'(bus.snapshot),   32'd0);
        chk("empty_valid",   32'(bus.snap_valid), 32'd1);

        // Maximum dwell on the top channel.
        run_scan(4'b1000, 255, 4'b1000);
        drain(400);
        chk("maxdw_done_at", 32'(done_at),      32'd257);
        chk("maxdw_snap",    32'(bus.snapshot), 32'b1000);

        // Middle channels, dwell 1, mixed input.
        run_scan(4'b0110, 1, 4'b0100);
        drain(20);
        chk("mid_done_at", 32'(done_at),      32'd5);
        chk("mid_busy",    32'(busy_cnt),     32'd4);
        chk("mid_snap",    32'(bus.snapshot), 32'b0100);

        // Reset asserted during cycle 3 of a scan.
        run_scan(4'b1111, 2, 4'b1111);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n  = 1'b1;
        q.delete();
        cur_e  = '0;
        tail_e = '0;
        chk("mrst_sel",   32'(sel),            32'd0);
        chk("mrst_busy",  32'(bus.busy),       32'd0);
        chk("mrst_snap",  32'(bus.snapshot),   32'd0);
        chk("mrst_valid", 32'(bus.snap_valid), 32'd0);
        tick();
        tick();
        tick();
        chk("mrst_no_done", 32'(done_cnt), 32'd0);

`ifdef MUX_SCAN_CONT_EN
        // Continuous mode: three passes, cont dropped in the third DONE.
        bus.cont = 1'b1;
        run_scan(4'b0011, 0, 4'b0010);
        expect_scan(4'b0011, 0, 4'b0010, 1'b0);
        expect_scan(4'b0011, 0, 4'b0010, 1'b0);
        for (int i = 0; i < 8; i++) tick();
        bus.cont = 1'b0;
        drain(20);
        chk("cont_done_cnt", 32'(done_cnt),     32'd3);
        chk("cont_done_at",  32'(done_at),      32'd9);
        chk("cont_snap",     32'(bus.snapshot), 32'b0010);
`endif

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
